// File: rtl/four_bit_adder_pkg.sv
// -----------------------------------------------------------------------------
// four_bit_adder_pkg
// Shared definitions for the registered nibble adder in the serial datapath.
//   ADDER_WIDTH : default operand/sum width used by four_bit_adder_reg
//   nibble_t    : convenience type for one operand or sum nibble
// -----------------------------------------------------------------------------
package four_bit_adder_pkg;

  localparam int ADDER_WIDTH = 4;

  typedef logic [ADDER_WIDTH-1:0] nibble_t;

endpackage : four_bit_adder_pkg

// File: rtl/full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
// Single-bit full adder, used as one stage of the ripple chain in
// four_bit_adder_reg.
// Ports:
//   a, b  : operand bits
//   cin   : carry in from the next lower stage
//   s     : sum bit
//   cout  : carry out to the next higher stage
// -----------------------------------------------------------------------------
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ cin;
  // Carry is generated by both inputs, or propagated from cin through a^b.
  assign cout     = (a & b) | (cin & half_sum);

endmodule : full_adder_bit

// File: rtl/four_bit_adder_reg.sv
// -----------------------------------------------------------------------------
// four_bit_adder_reg
// Registered unsigned adder between the SIPO and the PISO of the serial
// datapath. Sums the SIPO nibble with the register nibble and presents the
// result one clock after a valid input, together with the carry-out.
//
// Ports:
//   clk            : rising-edge clock
//   rst_n          : asynchronous active-low reset (clears all outputs)
//   in_valid       : operands valid this cycle
//   sipo_input     : operand A (unsigned)
//   register_input : operand B (unsigned)
//   piso_output    : registered sum
//   carry_out      : registered carry of the addition
//   out_valid      : piso_output/carry_out updated this cycle
//
// Build option:
//   FOUR_BIT_ADDER_SAT_EN : when defined, an overflowing sum registers as
//   all-ones instead of wrapping; carry_out still reports the overflow.
// -----------------------------------------------------------------------------
module four_bit_adder_reg
  import four_bit_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] sipo_input,
  input  logic [WIDTH-1:0] register_input,
  output logic [WIDTH-1:0] piso_output,
  output logic             carry_out,
  output logic             out_valid
);

  logic [WIDTH:0]   carry_chain;
  logic [WIDTH-1:0] sum_bits;
  logic [WIDTH-1:0] next_sum;

  // Ripple-carry chain; the chain starts with no carry in.
  assign carry_chain[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder_bit u_bit (
      .a    (sipo_input[i]),
      .b    (register_input[i]),
      .cin  (carry_chain[i]),
      .s    (sum_bits[i]),
      .cout (carry_chain[i+1])
    );
  end

`ifdef FOUR_BIT_ADDER_SAT_EN
  // Clamp to all-ones on overflow so the downstream sees the largest value.
  assign next_sum = carry_chain[WIDTH] ? {WIDTH{1'b1}} : sum_bits;
`else
  assign next_sum = sum_bits;
`endif

  // Result and carry update only on a valid input and otherwise hold, so
  // undriven operands while idle cannot disturb the outputs. out_valid is a
  // one-cycle strobe that follows in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      piso_output <= '0;
      carry_out   <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        piso_output <= next_sum;
        carry_out   <= carry_chain[WIDTH];
      end
    end
  end

endmodule : four_bit_adder_reg

// File: tb/tb_four_bit_adder_reg.sv
// -----------------------------------------------------------------------------
// tb_four_bit_adder_reg
// Self-checking bench for four_bit_adder_reg: directed vector table,
// hand-written reset/hold sequences, and randomized traffic compared against
// an arithmetic reference model. Honors FOUR_BIT_ADDER_SAT_EN.
// -----------------------------------------------------------------------------
module tb_four_bit_adder_reg;

`ifdef FOUR_BIT_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] sipo_input;
  logic [3:0] register_input;
  logic [3:0] piso_output;
  logic       carry_out;
  logic       out_valid;

  int tests_run;
  int tests_failed;

  // Reference model state: what the outputs should show after the last edge.
  logic [3:0] exp_sum;
  logic       exp_carry;
  logic       exp_valid;

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] wrap_sum;
    logic       carry;
  } vector_t;

  vector_t vectors[6];

  four_bit_adder_reg dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .sipo_input     (sipo_input),
    .register_input (register_input),
    .piso_output    (piso_output),
    .carry_out      (carry_out),
    .out_valid      (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected registered sum from plain integer arithmetic.
  function automatic logic [3:0] model_sum(input logic [3:0] a, input logic [3:0] b);
    int total;
    total = int'(a) + int'(b);
    if (total > 15 && SAT) return 4'hF;
    return 4'(total % 16);
  endfunction

  function automatic logic model_carry(input logic [3:0] a, input logic [3:0] b);
    return (int'(a) + int'(b)) > 15;
  endfunction

  // Drive one cycle of inputs away from the edge, update the model, then wait
  // until just after the capturing edge.
  task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [3:0] b);
    in_valid       = v;
    sipo_input     = a;
    register_input = b;
    if (v) begin
      exp_sum   = model_sum(a, b);
      exp_carry = model_carry(a, b);
    end
    exp_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] want_sum,
                             input logic want_carry, input logic want_valid);
    tests_run++;
    if (piso_output !== want_sum || carry_out !== want_carry || out_valid !== want_valid) begin
      tests_failed++;
      $display("[TB] FAIL %s: got sum=%h carry=%b valid=%b, expected sum=%h carry=%b valid=%b",
               name, piso_output, carry_out, out_valid, want_sum, want_carry, want_valid);
    end
  endtask

  initial begin
    logic [3:0] want;
    tests_run    = 0;
    tests_failed = 0;
    exp_sum      = 4'h0;
    exp_carry    = 1'b0;
    exp_valid    = 1'b0;

    vectors[0] = '{name: "basic_2p3",   a: 4'h2, b: 4'h3, wrap_sum: 4'h5, carry: 1'b0};
    vectors[1] = '{name: "b2b_6p1",     a: 4'h6, b: 4'h1, wrap_sum: 4'h7, carry: 1'b0};
    vectors[2] = '{name: "b2b_0p0",     a: 4'h0, b: 4'h0, wrap_sum: 4'h0, carry: 1'b0};
    vectors[3] = '{name: "ovf_Fp1",     a: 4'hF, b: 4'h1, wrap_sum: 4'h0, carry: 1'b1};
    vectors[4] = '{name: "ovf_FpF",     a: 4'hF, b: 4'hF, wrap_sum: 4'hE, carry: 1'b1};
    vectors[5] = '{name: "max_nocarry", a: 4'h8, b: 4'h7, wrap_sum: 4'hF, carry: 1'b0};

    // Reset held from time zero; outputs must already be cleared.
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    sipo_input     = 4'h0;
    register_input = 4'h0;
    #3;
    checkOutput("reset_state", 4'h0, 1'b0, 1'b0);
    #4;
    rst_n = 1'b1;

    // Directed table, applied back-to-back with in_valid held high.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vectors[i].a, vectors[i].b);
      want = (vectors[i].carry && SAT) ? 4'hF : vectors[i].wrap_sum;
      checkOutput(vectors[i].name, want, vectors[i].carry, 1'b1);
    end

    // Hold: register 0x5, then idle with other operands present.
    applyStimulus(1'b1, 4'h2, 4'h3);
    checkOutput("hold_setup", 4'h5, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'h9, 4'h9);
    checkOutput("hold_idle_9p9", 4'h5, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'bxxxx, 4'bxxxx);
    checkOutput("hold_idle_x", 4'h5, 1'b0, 1'b0);

    // Asynchronous reset between edges after a nonzero result with carry.
    applyStimulus(1'b1, 4'hF, 4'hF);
    checkOutput("pre_async_reset", SAT ? 4'hF : 4'hE, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 4'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    exp_sum   = 4'h0;
    exp_carry = 1'b0;
    applyStimulus(1'b0, 4'h0, 4'h0);
    checkOutput("after_release_idle", 4'h0, 1'b0, 1'b0);

    // Reset mid-stream: 0x4+0x4 is presented but reset lands before capture.
    in_valid       = 1'b1;
    sipo_input     = 4'h4;
    register_input = 4'h4;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midstream_reset", 4'h0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_sum   = 4'h0;
    exp_carry = 1'b0;
    applyStimulus(1'b0, 4'h4, 4'h4);
    checkOutput("midstream_no_8", 4'h0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 200; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom));
      checkOutput("random", exp_sum, exp_carry, exp_valid);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_four_bit_adder_reg
